// File: rtl/fpu_post_norm_round_pipe.sv
// Two-stage post-normalize / IEEE-754 round / pack pipeline for the FPU datapath.
// Stage 1 normalizes and classifies; stage 2 rounds, resolves overflow and packs.
module fpu_post_norm_round_pipe #(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 24,
    localparam int RES_W = 1 + EXP_W + MAN_W - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [MAN_W-1:0] in_man,
    input  logic [2:0]       in_grs,
    input  logic             in_cout,
    input  logic [1:0]       in_rnd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_result,
    output logic             out_ovf,
    output logic             out_unf,
    output logic             out_inexact
);

    localparam int W_W  = MAN_W + 3;
    localparam int LZ_W = $clog2(MAN_W);
    localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RUP = 2'b10,
        RM_RDN = 2'b11
    } rnd_mode_t;

    logic w_en1;
    logic w_en2;

    // ---------------- stage 1: normalize ----------------
    logic [LZ_W-1:0] w_lzc;
    logic [W_W-1:0]  w_wvec;
    logic [EXP_W:0]  w_exp_n;
    logic            w_zero;
    logic            w_unf;
    logic            w_ovf;

    always_comb begin
        w_lzc = '0;
        for (int unsigned i = 0; i < MAN_W; i++) begin
            if (in_man[i]) w_lzc = LZ_W'(MAN_W - 1 - i);
        end

        w_unf = 1'b0;
        if (in_cout) begin
            // dropped sticky bit folds into the new sticky position
            w_wvec  = {1'b1, in_man, in_grs[2], in_grs[1] | in_grs[0]};
            w_exp_n = {1'b0, in_exp} + (EXP_W+1)'(1);
        end else begin
            w_wvec  = {in_man, in_grs} << w_lzc;
            w_exp_n = {1'b0, in_exp} - (EXP_W+1)'(w_lzc);
        end

        // the hidden position is empty only for the zero class
        w_zero = !w_wvec[W_W-1];
        if (!in_cout && !w_zero) w_unf = (32'(w_lzc) >= 32'(in_exp));
        w_ovf = !w_zero && !w_unf && (w_exp_n >= EXP_MAX);
    end

    logic             r_v1;
    logic             r_s1;
    logic [EXP_W-1:0] r_e1;
    logic [W_W-2:0]   r_f1;
    rnd_mode_t        r_rnd1;
    logic             r_zero1;
    logic             r_unf1;
    logic             r_ovf1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_s1    <= 1'b0;
            r_e1    <= '0;
            r_f1    <= '0;
            r_rnd1  <= RM_RNE;
            r_zero1 <= 1'b0;
            r_unf1  <= 1'b0;
            r_ovf1  <= 1'b0;
        end else if (w_en1) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_s1    <= in_sign;
                r_e1    <= w_exp_n[EXP_W-1:0];
                r_f1    <= w_wvec[W_W-2:0];
                r_rnd1  <= rnd_mode_t'(in_rnd);
                r_zero1 <= w_zero;
                r_unf1  <= w_unf;
                r_ovf1  <= w_ovf;
            end
        end
    end

    // ---------------- stage 2: round and pack ----------------
    logic [MAN_W-2:0] w_frac;
    logic             w_g;
    logic             w_r;
    logic             w_s;
    logic             w_any;
    logic             w_inc;
    logic             w_to_inf;
    logic [MAN_W-1:0] w_sum;
    logic [EXP_W:0]   w_e2;
    logic             w_ovf2;
    logic [RES_W-1:0] w_res;
    logic             w_res_ovf;
    logic             w_res_unf;
    logic             w_res_inx;

    always_comb begin
        w_frac = r_f1[W_W-2:3];
        w_g    = r_f1[2];
        w_r    = r_f1[1];
        w_s    = r_f1[0];
        w_any  = w_g | w_r | w_s;

        w_inc    = 1'b0;
        w_to_inf = 1'b1;
        case (r_rnd1)
            RM_RNE: begin w_inc = w_g & (w_r | w_s | w_frac[0]); w_to_inf = 1'b1;   end
            RM_RTZ: begin w_inc = 1'b0;                          w_to_inf = 1'b0;   end
            RM_RUP: begin w_inc = !r_s1 & w_any;                 w_to_inf = !r_s1;  end
            RM_RDN: begin w_inc = r_s1 & w_any;                  w_to_inf = r_s1;   end
            default: begin w_inc = 1'b0;                         w_to_inf = 1'b1;   end
        endcase

        // carry out of the fraction leaves it all-zero, i.e. mantissa 100..0
        w_sum  = {1'b0, w_frac} + MAN_W'(w_inc);
        w_e2   = {1'b0, r_e1} + (EXP_W+1)'(w_sum[MAN_W-1]);
        w_ovf2 = !r_zero1 && !r_unf1 && (r_ovf1 || (w_e2 >= EXP_MAX));

        w_res     = {r_s1, w_e2[EXP_W-1:0], w_sum[MAN_W-2:0]};
        w_res_ovf = 1'b0;
        w_res_unf = 1'b0;
        w_res_inx = w_any;
        if (r_zero1) begin
            w_res = {r_s1, {(RES_W-1){1'b0}}};
        end else if (r_unf1) begin
            w_res     = {r_s1, {(RES_W-1){1'b0}}};
            w_res_unf = 1'b1;
            w_res_inx = 1'b1;
        end else if (w_ovf2) begin
            w_res_ovf = 1'b1;
            w_res_inx = 1'b1;
            if (w_to_inf) w_res = {r_s1, {EXP_W{1'b1}}, {(MAN_W-1){1'b0}}};
            else          w_res = {r_s1, {(EXP_W-1){1'b1}}, 1'b0, {(MAN_W-1){1'b1}}};
        end
    end

    logic             r_v2;
    logic [RES_W-1:0] r_res2;
    logic             r_ovf2;
    logic             r_unf2;
    logic             r_inx2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2   <= 1'b0;
            r_res2 <= '0;
            r_ovf2 <= 1'b0;
            r_unf2 <= 1'b0;
            r_inx2 <= 1'b0;
        end else if (w_en2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_res2 <= w_res;
                r_ovf2 <= w_res_ovf;
                r_unf2 <= w_res_unf;
                r_inx2 <= w_res_inx;
            end
        end
    end

    assign w_en2       = !r_v2 | out_ready;
    assign w_en1       = !r_v1 | w_en2;
    assign in_ready    = w_en1;
    assign out_valid   = r_v2;
    assign out_result  = r_res2;
    assign out_ovf     = r_ovf2;
    assign out_unf     = r_unf2;
    assign out_inexact = r_inx2;

endmodule
